// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, EX control bit positions,
// forwarding selects and multiplier FSM states.
package ex_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SHL  = 4'd5;
    localparam logic [3:0] ALU_SHR  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_MUL  = 4'd8;
    localparam logic [3:0] ALU_PASS = 4'd9;
    localparam logic [3:0] ALU_SLT  = 4'd10;

    localparam int EXB_SRC_IM = 4;
    localparam int EXB_SET_CC = 5;
    localparam int EXB_JR     = 6;
    localparam int EXB_BR     = 7;

    localparam logic [1:0] FW_REG     = 2'b00;
    localparam logic [1:0] FW_MA      = 2'b01;
    localparam logic [1:0] FW_WB      = 2'b10;
    localparam logic [1:0] FW_REG_ALT = 2'b11;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle, low DATA_W
// bits of the product held in DONE until the consumer acknowledges it.
module ex_mul_iter
    import ex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              ack,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    mul_state_e        state_q;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [DATA_W-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;

    // Abort shares the reset path so a flushed multiply leaves no partial product behind.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state_q  <= MUL_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                MUL_IDLE: begin
                    if (start) begin
                        mcand_q  <= a;
                        mplier_q <= b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    if (ack) begin
                        state_q <= MUL_IDLE;
                    end
                end
                default: state_q <= MUL_IDLE;
            endcase
        end
    end

    assign busy    = ((state_q == MUL_IDLE) && start) || (state_q == MUL_RUN);
    assign done    = (state_q == MUL_DONE);
    assign product = acc_q;

endmodule

// File: rtl/stage_ex.sv
// Execute stage: operand forwarding, ALU with NZCV flags, branch target, the
// iterative multiplier and the EX/MA pipeline register feeding stageMA.
module stage_ex
    import ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int MA_W   = 3,
    parameter int WB_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ex_valid,
    input  logic [DATA_W-1:0] i_ex_PC,
    input  logic [DATA_W-1:0] i_ex_OP1,
    input  logic [DATA_W-1:0] i_ex_OP2,
    input  logic [DATA_W-1:0] i_ex_IM,
    input  logic [RA_W-1:0]   i_ex_Rdst,
    input  logic [RA_W-1:0]   i_ex_Rs2_addr,
    input  logic [7:0]        i_ex_EX,
    input  logic [MA_W-1:0]   i_ex_MA,
    input  logic [WB_W-1:0]   i_ex_WB,
    input  logic [1:0]        i_OP1_ExS,
    input  logic [1:0]        i_OP2_ExS,
    input  logic [DATA_W-1:0] i_fw_ma,
    input  logic [DATA_W-1:0] i_fw_wb,
    input  logic              i_ex_stall,
    input  logic              i_ex_flush,
    output logic              o_ex_busy,
    output logic [3:0]        o_ex_cc4,
    output logic [DATA_W-1:0] o_ex_JmpAddr,
    output logic [DATA_W-1:0] o_ex_JmpInstrAddr,
    output logic              o_ex_Jump,
    output logic              o_ex_Branch,
    output logic              o_ex_valid,
    output logic [DATA_W-1:0] o_ex_PC,
    output logic [DATA_W-1:0] o_ex_ALU_rslt,
    output logic [DATA_W-1:0] o_ex_Rs2_val,
    output logic [RA_W-1:0]   o_ex_Rdst,
    output logic [RA_W-1:0]   o_ex_Rs2_addr,
    output logic [MA_W-1:0]   o_ex_MA,
    output logic [WB_W-1:0]   o_ex_WB
);

    localparam int SH_W = $clog2(DATA_W);

    logic [3:0]        alu_op;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] op_bsrc;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W:0]   sum_ext;
    logic              is_sub;
    logic [3:0]        flags;
    logic              mul_start;
    logic              mul_busy;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    logic              valid_q,    valid_d;
    logic [DATA_W-1:0] pc_q,       pc_d;
    logic [DATA_W-1:0] alu_q,      alu_d;
    logic [DATA_W-1:0] rs2_val_q,  rs2_val_d;
    logic [RA_W-1:0]   rdst_q,     rdst_d;
    logic [RA_W-1:0]   rs2_addr_q, rs2_addr_d;
    logic [MA_W-1:0]   ma_q,       ma_d;
    logic [WB_W-1:0]   wb_q,       wb_d;
    logic [3:0]        cc_q,       cc_d;

    assign alu_op = i_ex_EX[3:0];

    always_comb begin
        case (i_OP1_ExS)
            FW_MA:              op_a = i_fw_ma;
            FW_WB:              op_a = i_fw_wb;
            FW_REG, FW_REG_ALT: op_a = i_ex_OP1;
            default:            op_a = i_ex_OP1;
        endcase
        case (i_OP2_ExS)
            FW_MA:              op_b = i_fw_ma;
            FW_WB:              op_b = i_fw_wb;
            FW_REG, FW_REG_ALT: op_b = i_ex_OP2;
            default:            op_b = i_ex_OP2;
        endcase
        op_bsrc = i_ex_EX[EXB_SRC_IM] ? i_ex_IM : op_b;
    end

    assign mul_start = i_ex_valid && (alu_op == ALU_MUL) && !i_ex_flush;

    ex_mul_iter #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .abort   (i_ex_flush),
        .ack     (!i_ex_stall),
        .a       (op_a),
        .b       (op_bsrc),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // SUB runs through the same adder as a + ~b + 1, so carry-out means "no borrow".
    always_comb begin
        is_sub  = (alu_op == ALU_SUB);
        sum_ext = {1'b0, op_a} + {1'b0, (is_sub ? ~op_bsrc : op_bsrc)} + {{DATA_W{1'b0}}, is_sub};
        alu_res = '0;
        case (alu_op)
            ALU_ADD, ALU_SUB: alu_res = sum_ext[DATA_W-1:0];
            ALU_AND:  alu_res = op_a & op_bsrc;
            ALU_OR:   alu_res = op_a | op_bsrc;
            ALU_XOR:  alu_res = op_a ^ op_bsrc;
            ALU_SHL:  alu_res = op_a << op_bsrc[SH_W-1:0];
            ALU_SHR:  alu_res = op_a >> op_bsrc[SH_W-1:0];
            ALU_SRA:  alu_res = $signed(op_a) >>> op_bsrc[SH_W-1:0];
            ALU_MUL:  alu_res = mul_done ? mul_product : '0;
            ALU_PASS: alu_res = op_bsrc;
            ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_bsrc))};
            default:  alu_res = '0;
        endcase
        flags[3] = alu_res[DATA_W-1];
        flags[2] = (alu_res == '0);
        flags[1] = 1'b0;
        flags[0] = 1'b0;
        if (alu_op == ALU_ADD || alu_op == ALU_SUB) begin
            flags[1] = sum_ext[DATA_W];
            flags[0] = (op_a[DATA_W-1] == (is_sub ? ~op_bsrc[DATA_W-1] : op_bsrc[DATA_W-1]))
                       && (alu_res[DATA_W-1] != op_a[DATA_W-1]);
        end
    end

    // Flush beats stall; a busy multiplier inserts bubbles until its product is ready.
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        alu_d      = alu_q;
        rs2_val_d  = rs2_val_q;
        rdst_d     = rdst_q;
        rs2_addr_d = rs2_addr_q;
        ma_d       = ma_q;
        wb_d       = wb_q;
        cc_d       = cc_q;
        if (i_ex_flush || (!i_ex_stall && mul_busy)) begin
            valid_d    = 1'b0;
            pc_d       = '0;
            alu_d      = '0;
            rs2_val_d  = '0;
            rdst_d     = '0;
            rs2_addr_d = '0;
            ma_d       = '0;
            wb_d       = '0;
        end else if (!i_ex_stall) begin
            valid_d    = i_ex_valid;
            pc_d       = i_ex_PC;
            alu_d      = alu_res;
            rs2_val_d  = op_b;
            rdst_d     = i_ex_Rdst;
            rs2_addr_d = i_ex_Rs2_addr;
            ma_d       = i_ex_MA;
            wb_d       = i_ex_WB;
            if (i_ex_valid && i_ex_EX[EXB_SET_CC]) begin
                cc_d = flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            alu_q      <= '0;
            rs2_val_q  <= '0;
            rdst_q     <= '0;
            rs2_addr_q <= '0;
            ma_q       <= '0;
            wb_q       <= '0;
            cc_q       <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            alu_q      <= alu_d;
            rs2_val_q  <= rs2_val_d;
            rdst_q     <= rdst_d;
            rs2_addr_q <= rs2_addr_d;
            ma_q       <= ma_d;
            wb_q       <= wb_d;
            cc_q       <= cc_d;
        end
    end

    assign o_ex_busy         = mul_busy;
    assign o_ex_cc4          = cc_q;
    assign o_ex_JmpAddr      = i_ex_EX[EXB_JR] ? op_a : (i_ex_PC + i_ex_IM);
    assign o_ex_JmpInstrAddr = i_ex_PC;
    assign o_ex_Jump         = i_ex_valid && i_ex_EX[EXB_JR];
    assign o_ex_Branch       = i_ex_valid && i_ex_EX[EXB_BR];
    assign o_ex_valid        = valid_q;
    assign o_ex_PC           = pc_q;
    assign o_ex_ALU_rslt     = alu_q;
    assign o_ex_Rs2_val      = rs2_val_q;
    assign o_ex_Rdst         = rdst_q;
    assign o_ex_Rs2_addr     = rs2_addr_q;
    assign o_ex_MA           = ma_q;
    assign o_ex_WB           = wb_q;

endmodule

// File: tb/tb_stage_ex.sv
// Directed bench for stage_ex: flags, forwarding, ALU table, branch target,
// iterative multiply with and without flush, stall/flush behaviour of EX/MA.
module tb_stage_ex;

    logic        clk;
    logic        rst;
    logic        i_ex_valid;
    logic [31:0] i_ex_PC, i_ex_OP1, i_ex_OP2, i_ex_IM;
    logic [4:0]  i_ex_Rdst, i_ex_Rs2_addr;
    logic [7:0]  i_ex_EX;
    logic [2:0]  i_ex_MA, i_ex_WB;
    logic [1:0]  i_OP1_ExS, i_OP2_ExS;
    logic [31:0] i_fw_ma, i_fw_wb;
    logic        i_ex_stall, i_ex_flush;
    logic        o_ex_busy;
    logic [3:0]  o_ex_cc4;
    logic [31:0] o_ex_JmpAddr, o_ex_JmpInstrAddr;
    logic        o_ex_Jump, o_ex_Branch, o_ex_valid;
    logic [31:0] o_ex_PC, o_ex_ALU_rslt, o_ex_Rs2_val;
    logic [4:0]  o_ex_Rdst, o_ex_Rs2_addr;
    logic [2:0]  o_ex_MA, o_ex_WB;

    int checks = 0;
    int passes = 0;

    stage_ex dut (
        .clk               (clk),
        .rst               (rst),
        .i_ex_valid        (i_ex_valid),
        .i_ex_PC           (i_ex_PC),
        .i_ex_OP1          (i_ex_OP1),
        .i_ex_OP2          (i_ex_OP2),
        .i_ex_IM           (i_ex_IM),
        .i_ex_Rdst         (i_ex_Rdst),
        .i_ex_Rs2_addr     (i_ex_Rs2_addr),
        .i_ex_EX           (i_ex_EX),
        .i_ex_MA           (i_ex_MA),
        .i_ex_WB           (i_ex_WB),
        .i_OP1_ExS         (i_OP1_ExS),
        .i_OP2_ExS         (i_OP2_ExS),
        .i_fw_ma           (i_fw_ma),
        .i_fw_wb           (i_fw_wb),
        .i_ex_stall        (i_ex_stall),
        .i_ex_flush        (i_ex_flush),
        .o_ex_busy         (o_ex_busy),
        .o_ex_cc4          (o_ex_cc4),
        .o_ex_JmpAddr      (o_ex_JmpAddr),
        .o_ex_JmpInstrAddr (o_ex_JmpInstrAddr),
        .o_ex_Jump         (o_ex_Jump),
        .o_ex_Branch       (o_ex_Branch),
        .o_ex_valid        (o_ex_valid),
        .o_ex_PC           (o_ex_PC),
        .o_ex_ALU_rslt     (o_ex_ALU_rslt),
        .o_ex_Rs2_val      (o_ex_Rs2_val),
        .o_ex_Rdst         (o_ex_Rdst),
        .o_ex_Rs2_addr     (o_ex_Rs2_addr),
        .o_ex_MA           (o_ex_MA),
        .o_ex_WB           (o_ex_WB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // EX control byte: {branch, jump-reg, set-CC, src2=IM, alu_op}
    function automatic logic [7:0] exc(input logic br, input logic jr, input logic cc,
                                       input logic im, input logic [3:0] op);
        return {br, jr, cc, im, op};
    endfunction

    task automatic drive(input logic v, input logic [7:0] ex, input logic [31:0] op1,
                         input logic [31:0] op2, input logic [31:0] im,
                         input logic [1:0] s1, input logic [1:0] s2);
        i_ex_valid = v;
        i_ex_EX    = ex;
        i_ex_OP1   = op1;
        i_ex_OP2   = op2;
        i_ex_IM    = im;
        i_OP1_ExS  = s1;
        i_OP2_ExS  = s2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, exc(0, 0, 1, 0, 4'd0), 32'd1, 32'd1, 32'd0, 2'b00, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (o_ex_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", o_ex_valid); else passes++;
        checks++; if (o_ex_ALU_rslt !== 32'h0) $display("FAIL reset_alu: got %h expected 00000000", o_ex_ALU_rslt); else passes++;
        checks++; if (o_ex_cc4 !== 4'h0) $display("FAIL reset_cc4: got %b expected 0000", o_ex_cc4); else passes++;
        checks++; if ({o_ex_MA, o_ex_WB} !== 6'h0) $display("FAIL reset_ma_wb: got %h expected 00", {o_ex_MA, o_ex_WB}); else passes++;
        checks++; if (o_ex_busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", o_ex_busy); else passes++;
        @(negedge clk);
        rst = 1'b0;
        $display("test_reset: valid=%0b cc4=%b busy=%0b", o_ex_valid, o_ex_cc4, o_ex_busy);
    endtask

    task automatic test_add_flags();
        @(negedge clk);
        i_ex_PC = 32'h44; i_ex_Rdst = 5'd7; i_ex_MA = 3'd2; i_ex_WB = 3'd5;
        drive(1'b1, exc(0, 0, 1, 0, 4'd0), 32'h7FFFFFFF, 32'd1, 32'd0, 2'b00, 2'b00);
        @(posedge clk); #1;
        checks++; if (o_ex_ALU_rslt !== 32'h80000000) $display("FAIL add_rslt: got %h expected 80000000", o_ex_ALU_rslt); else passes++;
        checks++; if (o_ex_cc4 !== 4'b1001) $display("FAIL add_cc4: got %b expected 1001", o_ex_cc4); else passes++;
        checks++; if ({o_ex_valid, o_ex_Rdst, o_ex_MA, o_ex_WB, o_ex_PC} !== {1'b1, 5'd7, 3'd2, 3'd5, 32'h44})
            $display("FAIL add_fields: got v=%0b rd=%0d ma=%0d wb=%0d pc=%h expected v=1 rd=7 ma=2 wb=5 pc=44",
                     o_ex_valid, o_ex_Rdst, o_ex_MA, o_ex_WB, o_ex_PC);
        else passes++;
        $display("test_add_flags: rslt=%h cc4=%b", o_ex_ALU_rslt, o_ex_cc4);
    endtask

    task automatic test_sub_forward();
        @(negedge clk);
        i_fw_ma = 32'd5;
        drive(1'b1, exc(0, 0, 1, 0, 4'd1), 32'd5, 32'd9, 32'd0, 2'b00, 2'b01);
        @(posedge clk); #1;
        checks++; if (o_ex_ALU_rslt !== 32'h0) $display("FAIL sub_rslt: got %h expected 00000000", o_ex_ALU_rslt); else passes++;
        checks++; if (o_ex_cc4 !== 4'b0110) $display("FAIL sub_cc4: got %b expected 0110", o_ex_cc4); else passes++;
        checks++; if (o_ex_Rs2_val !== 32'd5) $display("FAIL sub_rs2_val: got %h expected 00000005", o_ex_Rs2_val); else passes++;
        $display("test_sub_forward: rslt=%h cc4=%b rs2=%h", o_ex_ALU_rslt, o_ex_cc4, o_ex_Rs2_val);
    endtask

    task automatic test_alu_table();
        logic [3:0]  t_op  [11] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd9, 4'd12, 4'd0, 4'd10};
        logic        t_im  [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0]  t_s1  [11] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00};
        logic [31:0] t_a   [11] = '{32'hF0F01234, 32'hF0000000, 32'h1, 32'h1, 32'h80000000, 32'h80000000,
                                    32'hFFFFFFFF, 32'h0, 32'h5, 32'h3, 32'h1};
        logic [31:0] t_b   [11] = '{32'h0FF0FFFF, 32'h0000000F, 32'h00FF00FF, 32'h0, 32'h1F, 32'h4,
                                    32'h1, 32'h0, 32'h6, 32'h4, 32'hFFFFFFFF};
        logic [31:0] t_imm [11] = '{32'h0, 32'h0, 32'h0, 32'h24, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF,
                                    32'h0, 32'h0, 32'h0};
        logic [31:0] t_exp [11] = '{32'h00F01234, 32'hF000000F, 32'hFF0000FF, 32'h10, 32'h1, 32'hF8000000,
                                    32'h1, 32'hDEADBEEF, 32'h0, 32'h7, 32'h0};
        i_fw_ma = 32'h100;
        i_fw_wb = 32'hFFFF0000;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(1'b1, exc(0, 0, 0, t_im[i], t_op[i]), t_a[i], t_b[i], t_imm[i], t_s1[i], 2'b00);
            @(posedge clk); #1;
            checks++;
            if (o_ex_ALU_rslt !== t_exp[i]) $display("FAIL alu_vec%0d: got %h expected %h", i, o_ex_ALU_rslt, t_exp[i]);
            else passes++;
            $display("test_alu_table: op=%0d rslt=%h", t_op[i], o_ex_ALU_rslt);
        end
        checks++; if (o_ex_cc4 !== 4'b0110) $display("FAIL alu_cc_hold: got %b expected 0110", o_ex_cc4); else passes++;
    endtask

    task automatic test_branch();
        @(negedge clk);
        i_ex_PC = 32'h100;
        drive(1'b1, exc(1, 0, 0, 1, 4'd0), 32'h0, 32'h0, 32'h20, 2'b00, 2'b00);
        #1;
        checks++; if (o_ex_JmpAddr !== 32'h120) $display("FAIL br_addr: got %h expected 00000120", o_ex_JmpAddr); else passes++;
        checks++; if ({o_ex_Branch, o_ex_Jump} !== 2'b10) $display("FAIL br_flags: got %b expected 10", {o_ex_Branch, o_ex_Jump}); else passes++;
        checks++; if (o_ex_JmpInstrAddr !== 32'h100) $display("FAIL br_instr_addr: got %h expected 00000100", o_ex_JmpInstrAddr); else passes++;
        drive(1'b1, exc(0, 1, 0, 0, 4'd0), 32'h400, 32'h0, 32'h20, 2'b00, 2'b00);
        #1;
        checks++; if (o_ex_JmpAddr !== 32'h400) $display("FAIL jr_addr: got %h expected 00000400", o_ex_JmpAddr); else passes++;
        checks++; if ({o_ex_Branch, o_ex_Jump} !== 2'b01) $display("FAIL jr_flags: got %b expected 01", {o_ex_Branch, o_ex_Jump}); else passes++;
        i_ex_valid = 1'b0;
        #1;
        checks++; if (o_ex_Jump !== 1'b0) $display("FAIL jr_invalid: got %0b expected 0", o_ex_Jump); else passes++;
        $display("test_branch: jr_addr=%h", o_ex_JmpAddr);
    endtask

    task automatic test_mul();
        int cycles = 0;
        logic bubble_bad = 1'b0;
        @(negedge clk);
        drive(1'b1, exc(0, 0, 1, 0, 4'd8), 32'h12345678, 32'h10, 32'h0, 2'b00, 2'b00);
        #1;
        checks++; if (o_ex_busy !== 1'b1) $display("FAIL mul_busy_start: got %0b expected 1", o_ex_busy); else passes++;
        while (o_ex_busy === 1'b1 && cycles < 60) begin
            @(posedge clk); #1;
            cycles++;
            if (o_ex_valid !== 1'b0) bubble_bad = 1'b1;
        end
        checks++; if (cycles != 33) $display("FAIL mul_busy_cycles: got %0d expected 33", cycles); else passes++;
        checks++; if (bubble_bad !== 1'b0) $display("FAIL mul_bubbles: got valid during busy, expected 0"); else passes++;
        @(posedge clk); #1;
        checks++; if (o_ex_ALU_rslt !== 32'h23456780) $display("FAIL mul_rslt: got %h expected 23456780", o_ex_ALU_rslt); else passes++;
        checks++; if (o_ex_valid !== 1'b1) $display("FAIL mul_valid: got %0b expected 1", o_ex_valid); else passes++;
        checks++; if (o_ex_cc4 !== 4'b0000) $display("FAIL mul_cc4: got %b expected 0000", o_ex_cc4); else passes++;
        i_ex_valid = 1'b0;
        $display("test_mul: cycles=%0d rslt=%h", cycles, o_ex_ALU_rslt);
    endtask

    task automatic test_mul_flush();
        @(negedge clk);
        drive(1'b1, exc(0, 0, 0, 0, 4'd8), 32'd3, 32'd7, 32'h0, 2'b00, 2'b00);
        repeat (10) @(posedge clk);
        #1;
        checks++; if (o_ex_busy !== 1'b1) $display("FAIL flush_busy_before: got %0b expected 1", o_ex_busy); else passes++;
        @(negedge clk);
        i_ex_flush = 1'b1;
        @(posedge clk); #1;
        i_ex_flush = 1'b0;
        drive(1'b1, exc(0, 0, 0, 0, 4'd0), 32'd2, 32'd3, 32'h0, 2'b00, 2'b00);
        #1;
        checks++; if (o_ex_busy !== 1'b0) $display("FAIL flush_busy_after: got %0b expected 0", o_ex_busy); else passes++;
        checks++; if (o_ex_valid !== 1'b0) $display("FAIL flush_valid: got %0b expected 0", o_ex_valid); else passes++;
        @(posedge clk); #1;
        checks++; if ({o_ex_valid, o_ex_ALU_rslt} !== {1'b1, 32'd5})
            $display("FAIL flush_next_add: got v=%0b rslt=%h expected v=1 rslt=00000005", o_ex_valid, o_ex_ALU_rslt);
        else passes++;
        $display("test_mul_flush: next rslt=%h", o_ex_ALU_rslt);
    endtask

    task automatic test_stall();
        @(negedge clk);
        drive(1'b1, exc(0, 0, 1, 0, 4'd0), 32'h7FFFFFFF, 32'd1, 32'h0, 2'b00, 2'b00);
        @(posedge clk); #1;
        checks++; if (o_ex_cc4 !== 4'b1001) $display("FAIL stall_pre_cc4: got %b expected 1001", o_ex_cc4); else passes++;
        @(negedge clk);
        i_ex_stall = 1'b1;
        drive(1'b1, exc(0, 0, 1, 0, 4'd0), 32'hFFFFFFFF, 32'd1, 32'h0, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({o_ex_ALU_rslt, o_ex_cc4} !== {32'h80000000, 4'b1001})
                $display("FAIL stall_hold%0d: got rslt=%h cc4=%b expected rslt=80000000 cc4=1001", i, o_ex_ALU_rslt, o_ex_cc4);
            else passes++;
        end
        @(negedge clk);
        i_ex_stall = 1'b0;
        @(posedge clk); #1;
        checks++; if (o_ex_ALU_rslt !== 32'h0) $display("FAIL stall_release_rslt: got %h expected 00000000", o_ex_ALU_rslt); else passes++;
        checks++; if (o_ex_cc4 !== 4'b0110) $display("FAIL stall_release_cc4: got %b expected 0110", o_ex_cc4); else passes++;
        @(negedge clk);
        i_ex_stall = 1'b1;
        i_ex_flush = 1'b1;
        @(posedge clk); #1;
        checks++; if (o_ex_valid !== 1'b0) $display("FAIL flush_beats_stall: got %0b expected 0", o_ex_valid); else passes++;
        i_ex_stall = 1'b0;
        i_ex_flush = 1'b0;
        $display("test_stall: rslt=%h cc4=%b", o_ex_ALU_rslt, o_ex_cc4);
    endtask

    initial begin
        rst = 1'b1;
        i_ex_PC = '0; i_ex_Rdst = '0; i_ex_Rs2_addr = 5'd3; i_ex_MA = '0; i_ex_WB = '0;
        i_fw_ma = '0; i_fw_wb = '0; i_ex_stall = 1'b0; i_ex_flush = 1'b0;
        drive(1'b0, 8'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00);
        test_reset();
        test_add_flags();
        test_sub_forward();
        test_alu_table();
        test_branch();
        test_mul();
        test_mul_flush();
        test_stall();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
